// File: rtl/secded_axis_pipe.sv
// secded_axis_pipe: two-stage SECDED (extended Hamming) encode -> fault inject -> decode/correct over AXI-Stream.
// Fault injection is compiled in only when ECC_INJECT_EN is defined.
module secded_axis_pipe #(
    parameter int DATA_W = 16,
    parameter int PAR_W  = 5,
    parameter int CNT_W  = 16,
    localparam int CODE_W = DATA_W + PAR_W + 1,
    localparam int POS_W  = $clog2(CODE_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic              inject,
    input  logic [POS_W-1:0]  fault_pos,
    input  logic              double_error,
    output logic              single_error_flag,
    output logic              double_error_flag,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sec_count,
    output logic [CNT_W-1:0]  ded_count
);

    localparam logic [PAR_W:0]    CODE_W_SYN = (PAR_W + 1)'(CODE_W);
    localparam logic [POS_W:0]    CODE_W_POS = (POS_W + 1)'(CODE_W);
    localparam logic [CODE_W-1:0] CODE_ONE   = {{(CODE_W - 1){1'b0}}, 1'b1};

    // Parity must cover every Hamming position, and no more parity bits than the codeword can hold.
    generate
        if (DATA_W < 4 || DATA_W > 64 || (2 ** PAR_W) < CODE_W || (2 ** (PAR_W - 1)) >= CODE_W) begin : g_bad_cfg
            $error("secded_axis_pipe: invalid DATA_W/PAR_W combination");
        end
    endgenerate

    function automatic logic [PAR_W-1:0] f_syndrome(input logic [CODE_W-1:0] code);
        logic [PAR_W-1:0] syn;
        syn = '0;
        for (int p = 32'sd1; p < CODE_W; p++) begin
            if (code[p]) begin
                syn = syn ^ p[PAR_W-1:0];
            end else begin
                syn = syn;
            end
        end
        return syn;
    endfunction

    function automatic logic [CODE_W-1:0] f_encode(input logic [DATA_W-1:0] data);
        logic [CODE_W-1:0] code;
        logic [PAR_W-1:0]  syn;
        int                k;
        code = '0;
        k    = 32'sd0;
        for (int p = 32'sd1; p < CODE_W; p++) begin
            if ((p & (p - 32'sd1)) != 32'sd0) begin
                code[p] = data[k];
                k       = k + 32'sd1;
            end else begin
                code[p] = 1'b0;
            end
        end
        // Placing the data syndrome into the power-of-two slots drives the total syndrome to zero.
        syn = f_syndrome(code);
        for (int i = 32'sd0; i < PAR_W; i++) begin
            code[2 ** i] = syn[i];
        end
        code[0] = ^code[CODE_W-1:1];
        return code;
    endfunction

    function automatic logic [DATA_W-1:0] f_extract(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] data;
        int                k;
        data = '0;
        k    = 32'sd0;
        for (int p = 32'sd1; p < CODE_W; p++) begin
            if ((p & (p - 32'sd1)) != 32'sd0) begin
                data[k] = code[p];
                k       = k + 32'sd1;
            end else begin
                k = k;
            end
        end
        return data;
    endfunction

    logic              r_s1_valid;
    logic [CODE_W-1:0] r_s1_code;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    logic              r_s2_sec;
    logic              r_s2_ded;
    logic [CNT_W-1:0]  r_sec_count;
    logic [CNT_W-1:0]  r_ded_count;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_out_hs;
    logic [CODE_W-1:0] w_mask;
    logic [PAR_W-1:0]  w_syn;
    logic              w_pm;
    logic [CODE_W-1:0] w_fixed;
    logic              w_sec;
    logic              w_ded;

    assign w_s2_adv      = ~r_s2_valid | m_axis_tready;
    assign w_s1_adv      = ~r_s1_valid | w_s2_adv;
    assign s_axis_tready = reset & w_s1_adv;
    assign w_out_hs      = r_s2_valid & m_axis_tready;

`ifdef ECC_INJECT_EN
    logic [POS_W:0] w_pos2;

    // Build the flip mask; the second flip wraps from the top codeword bit to bit 0.
    always_comb begin
        w_mask = '0;
        w_pos2 = {1'b0, fault_pos} + {{POS_W{1'b0}}, 1'b1};
        if (w_pos2 == CODE_W_POS) begin
            w_pos2 = '0;
        end else begin
            w_pos2 = w_pos2;
        end
        if (inject) begin
            if ({1'b0, fault_pos} < CODE_W_POS) begin
                w_mask = w_mask | (CODE_ONE << fault_pos);
            end else begin
                w_mask = w_mask;
            end
            if (double_error && (w_pos2 < CODE_W_POS)) begin
                w_mask = w_mask | (CODE_ONE << w_pos2);
            end else begin
                w_mask = w_mask;
            end
        end else begin
            w_mask = '0;
        end
    end
`else
    logic w_unused_inj;
    assign w_mask       = '0;
    assign w_unused_inj = ^{inject, fault_pos, double_error};
`endif

    // Stage 1: encode the accepted beat and apply any injected flips.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= s_axis_tvalid;
            r_s1_code  <= f_encode(s_axis_tdata) ^ w_mask;
        end
    end

    // Classify the stage-1 codeword and correct a single flipped bit.
    always_comb begin
        w_syn   = f_syndrome(r_s1_code);
        w_pm    = ^r_s1_code;
        w_fixed = r_s1_code;
        w_sec   = 1'b0;
        w_ded   = 1'b0;
        if (!w_pm) begin
            if (w_syn == '0) begin
                w_sec = 1'b0;
            end else begin
                w_ded = 1'b1;
            end
        end else if (w_syn == '0) begin
            w_sec = 1'b1;
        end else if ({1'b0, w_syn} < CODE_W_SYN) begin
            w_sec   = 1'b1;
            w_fixed = r_s1_code ^ (CODE_ONE << w_syn);
        end else begin
            w_ded = 1'b1;
        end
    end

    // Stage 2 is the output register and holds its beat while downstream stalls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_sec   <= 1'b0;
            r_s2_ded   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= f_extract(w_fixed);
                r_s2_sec  <= w_sec;
                r_s2_ded  <= w_ded;
            end
        end
    end

    // Saturating event counters; a coincident clear takes priority over an increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sec_count <= '0;
            r_ded_count <= '0;
        end else if (cnt_clr) begin
            r_sec_count <= '0;
            r_ded_count <= '0;
        end else begin
            if (w_out_hs && r_s2_sec && !(&r_sec_count)) begin
                r_sec_count <= r_sec_count + {{(CNT_W - 1){1'b0}}, 1'b1};
            end
            if (w_out_hs && r_s2_ded && !(&r_ded_count)) begin
                r_ded_count <= r_ded_count + {{(CNT_W - 1){1'b0}}, 1'b1};
            end
        end
    end

    assign m_axis_tvalid     = r_s2_valid;
    assign m_axis_tdata      = r_s2_data;
    assign single_error_flag = r_s2_sec;
    assign double_error_flag = r_s2_ded;
    assign sec_count         = r_sec_count;
    assign ded_count         = r_ded_count;

endmodule

// File: tb/tb_secded_axis_pipe.sv
// Self-checking bench for secded_axis_pipe: directed scenarios plus a randomized stream with backpressure.
module tb_secded_axis_pipe;

    localparam int DW   = 16;
    localparam int CW   = 22;
    localparam int POSW = 5;
    localparam int CNTW = 4;
    localparam int CMAX = 15;
`ifdef ECC_INJECT_EN
    localparam bit INJ_ON = 1'b1;
`else
    localparam bit INJ_ON = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sec;
        logic          ded;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [DW-1:0]   s_axis_tdata;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            inject;
    logic [POSW-1:0] fault_pos;
    logic            double_error;
    logic            single_error_flag;
    logic            double_error_flag;
    logic            cnt_clr;
    logic [CNTW-1:0] sec_count;
    logic [CNTW-1:0] ded_count;

    int n_vec = 0;
    int n_err = 0;
    int sec_m = 0;
    int ded_m = 0;

    secded_axis_pipe #(.DATA_W(DW), .PAR_W(5), .CNT_W(CNTW)) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .inject(inject), .fault_pos(fault_pos), .double_error(double_error),
        .single_error_flag(single_error_flag), .double_error_flag(double_error_flag),
        .cnt_clr(cnt_clr), .sec_count(sec_count), .ded_count(ded_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit is_pow2(int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Data index of a non-power-of-two Hamming position: position minus the parity slots at or below it, minus one.
    function automatic int didx(int p);
        int cnt = 0;
        for (int k = 1; k <= p; k = k * 2) cnt++;
        return p - cnt - 1;
    endfunction

    function automatic exp_t model(logic [DW-1:0] d, logic inj, logic [POSW-1:0] pos, logic dbl);
        exp_t e;
        int   flips[$];
        int   p2;
        e.data = d;
        e.sec  = 1'b0;
        e.ded  = 1'b0;
        if (INJ_ON && inj) begin
            if (int'(pos) < CW) flips.push_back(int'(pos));
            if (dbl) begin
                p2 = int'(pos) + 1;
                if (p2 == CW) p2 = 0;
                if (p2 < CW) flips.push_back(p2);
            end
        end
        if (flips.size() == 1) begin
            e.sec = 1'b1;
        end else if (flips.size() == 2) begin
            e.ded = 1'b1;
            foreach (flips[i])
                if (flips[i] > 0 && !is_pow2(flips[i])) e.data = e.data ^ (16'h0001 << didx(flips[i]));
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        n_vec++; if (m_axis_tdata !== 16'h0000) begin n_err++; $display("FAIL reset_tdata: got %h want 0000", m_axis_tdata); end
        n_vec++; if ({single_error_flag, double_error_flag} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b%b want 00", single_error_flag, double_error_flag); end
        n_vec++; if ({sec_count, ded_count} !== 8'h00) begin n_err++; $display("FAIL reset_counts: got %0d/%0d want 0/0", sec_count, ded_count); end
        n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready_low: got %b want 0", s_axis_tready); end
        reset = 1'b1;
        #1;
        n_vec++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL reset_tready_release: got %b want 1", s_axis_tready); end
    endtask

    task automatic test_beat(input logic [DW-1:0] d, input logic inj, input logic [POSW-1:0] pos, input logic dbl);
        exp_t e;
        e = model(d, inj, pos, dbl);
        s_axis_tdata = d; s_axis_tvalid = 1'b1; inject = inj; fault_pos = pos; double_error = dbl;
        m_axis_tready = 1'b1;
        #1;
        n_vec++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL beat_accept %h: tready got %b want 1", d, s_axis_tready); end
        step();
        s_axis_tvalid = 1'b0; inject = 1'b0; double_error = 1'b0;
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL beat_latency1 %h: tvalid got %b want 0", d, m_axis_tvalid); end
        step();
        n_vec++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL beat_latency2 %h: tvalid got %b want 1", d, m_axis_tvalid); end
        n_vec++; if (m_axis_tdata !== e.data) begin n_err++; $display("FAIL beat_data %h: got %h want %h", d, m_axis_tdata, e.data); end
        n_vec++; if ({single_error_flag, double_error_flag} !== {e.sec, e.ded}) begin
            n_err++; $display("FAIL beat_flags %h: got sec=%b ded=%b want sec=%b ded=%b", d, single_error_flag, double_error_flag, e.sec, e.ded); end
        if (e.sec && sec_m < CMAX) sec_m++;
        if (e.ded && ded_m < CMAX) ded_m++;
        step();
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL beat_drain %h: tvalid got %b want 0", d, m_axis_tvalid); end
        n_vec++; if (sec_count !== CNTW'(sec_m) || ded_count !== CNTW'(ded_m)) begin
            n_err++; $display("FAIL beat_counts %h: got %0d/%0d want %0d/%0d", d, sec_count, ded_count, sec_m, ded_m); end
    endtask

    task automatic test_back_to_back();
        int            sent = 0;
        int            got = 0;
        int            cyc = 0;
        bit            stalled = 1'b0;
        logic [DW-1:0] prev = '0;
        while (got < 8 && cyc < 40) begin
            s_axis_tvalid = (sent < 8); s_axis_tdata = 16'(sent + 1); inject = 1'b0;
            m_axis_tready = !(cyc >= 3 && cyc <= 5);
            #1;
            if (stalled) begin
                n_vec++; if (m_axis_tdata !== prev) begin n_err++; $display("FAIL b2b_stable: got %h want %h", m_axis_tdata, prev); end
            end
            if (s_axis_tvalid && s_axis_tready) sent++;
            if (m_axis_tvalid && m_axis_tready) begin
                n_vec++; if (m_axis_tdata !== 16'(got + 1) || single_error_flag || double_error_flag) begin
                    n_err++; $display("FAIL b2b_order: got %h flags %b%b want %h flags 00", m_axis_tdata, single_error_flag, double_error_flag, 16'(got + 1)); end
                got++;
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            prev = m_axis_tdata;
            step();
            cyc++;
        end
        n_vec++; if (got != 8) begin n_err++; $display("FAIL b2b_count: got %0d beats want 8", got); end
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        step();
        step();
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL b2b_dup: tvalid got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_random();
        exp_t          q[$];
        exp_t          e;
        int            sent = 0;
        int            cyc = 0;
        bit            have = 1'b0;
        bit            stalled = 1'b0;
        logic [DW+1:0] prev = '0;
        while ((sent < 300 || have || q.size() != 0) && cyc < 4000) begin
            if (!have && sent < 300 && $urandom_range(3, 0) != 0) begin
                s_axis_tdata = 16'($urandom);
                inject       = ($urandom_range(2, 0) != 0);
                fault_pos    = POSW'($urandom_range(31, 0));
                double_error = ($urandom_range(1, 0) == 1);
                have = 1'b1;
                sent++;
            end
            s_axis_tvalid = have;
            m_axis_tready = ($urandom_range(3, 0) != 0);
            #1;
            if (stalled) begin
                n_vec++; if ({m_axis_tdata, single_error_flag, double_error_flag} !== prev) begin
                    n_err++; $display("FAIL rnd_stable: got %h want %h", {m_axis_tdata, single_error_flag, double_error_flag}, prev); end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                q.push_back(model(s_axis_tdata, inject, fault_pos, double_error));
                have = 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rnd_extra: unexpected beat %h", m_axis_tdata);
                end else begin
                    e = q.pop_front();
                    if ({m_axis_tdata, single_error_flag, double_error_flag} !== {e.data, e.sec, e.ded}) begin
                        n_err++; $display("FAIL rnd_beat: got %h sec=%b ded=%b want %h sec=%b ded=%b",
                            m_axis_tdata, single_error_flag, double_error_flag, e.data, e.sec, e.ded); end
                    if (e.sec && sec_m < CMAX) sec_m++;
                    if (e.ded && ded_m < CMAX) ded_m++;
                end
            end
            if (m_axis_tvalid) begin
                n_vec++; if (single_error_flag && double_error_flag) begin n_err++; $display("FAIL rnd_excl: got both flags want at most one"); end
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            prev = {m_axis_tdata, single_error_flag, double_error_flag};
            step();
            cyc++;
            n_vec++; if (sec_count !== CNTW'(sec_m) || ded_count !== CNTW'(ded_m)) begin
                n_err++; $display("FAIL rnd_counts: got %0d/%0d want %0d/%0d", sec_count, ded_count, sec_m, ded_m); end
        end
        n_vec++; if (q.size() != 0 || have) begin n_err++; $display("FAIL rnd_timeout: %0d beats outstanding want 0", q.size()); end
        s_axis_tvalid = 1'b0; inject = 1'b0; double_error = 1'b0; m_axis_tready = 1'b1;
        step();
    endtask

    task automatic test_cnt_clr();
        s_axis_tdata = 16'h3C3C; s_axis_tvalid = 1'b1; inject = 1'b1; fault_pos = 5'd9; double_error = 1'b0;
        m_axis_tready = 1'b1;
        step();
        s_axis_tvalid = 1'b0; inject = 1'b0;
        step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        sec_m = 0; ded_m = 0;
        n_vec++; if (sec_count !== 4'd0 || ded_count !== 4'd0) begin
            n_err++; $display("FAIL cnt_clr: got %0d/%0d want 0/0", sec_count, ded_count); end
    endtask

    task automatic test_reset_inflight();
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = 16'h1111;
        step();
        s_axis_tdata = 16'h2222;
        step();
        s_axis_tvalid = 1'b0;
        n_vec++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL inflight_setup: tvalid got %b want 1", m_axis_tvalid); end
        reset = 1'b0;
        #1;
        n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL inflight_tready: got %b want 0", s_axis_tready); end
        step();
        n_vec++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 16'h0000) begin
            n_err++; $display("FAIL inflight_flush: tvalid %b tdata %h want 0 0000", m_axis_tvalid, m_axis_tdata); end
        n_vec++; if (sec_count !== 4'd0 || ded_count !== 4'd0) begin
            n_err++; $display("FAIL inflight_counts: got %0d/%0d want 0/0", sec_count, ded_count); end
        reset = 1'b1; sec_m = 0; ded_m = 0; m_axis_tready = 1'b1;
        step();
        step();
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL inflight_discard: tvalid got %b want 0", m_axis_tvalid); end
    endtask

    initial begin
        reset = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        inject = 1'b0; fault_pos = '0; double_error = 1'b0; cnt_clr = 1'b0;
        test_reset();
        test_beat(16'hA5A5, 1'b0, 5'd0, 1'b0);
        test_beat(16'h5A5A, 1'b1, 5'd5, 1'b0);
        test_beat(16'hF0F0, 1'b1, 5'd7, 1'b1);
        test_back_to_back();
        test_beat(16'h1234, 1'b1, 5'd0, 1'b0);
        test_beat(16'hBEEF, 1'b1, 5'd21, 1'b1);
        test_beat(16'hCAFE, 1'b1, 5'd30, 1'b1);
        test_beat(16'h0F0F, 1'b1, 5'd16, 1'b0);
        test_random();
        test_cnt_clr();
        test_beat(16'h0F0F, 1'b1, 5'd3, 1'b0);
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
